// File: rtl/bus_interface_unit.sv
// Multiplexed address/data bus master: one core request becomes an ADL/ADH/DATA/DONE
// sequence on shared 8-bit pins, with external address latches strobed by ale_lo/ale_hi.
module bus_interface_unit #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_enable,
   input  logic        req_valid,
   input  logic        req_rw,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   input  logic [7:0]  uio_in,
   output logic [7:0]  uio_out,
   output logic [7:0]  uio_oe,
   output logic        ale_lo,
   output logic        ale_hi,
   output logic        mem_oe_n,
   output logic        mem_we_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADL,
      S_ADH,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [2:0] WaitLoad = 3'(WAIT_STATES);

   state_t      state;
   state_t      state_nxt;
   logic        rw_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic        hi_valid;
   logic [7:0]  last_hi;
   logic [2:0]  wait_cnt;
   logic        hi_skip;

   // The external high-address latch still holds last_hi, so re-strobing it is skipped.
   assign hi_skip = hi_valid && (addr_q[15:8] == last_hi);

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      uio_out   = 8'h00;
      uio_oe    = 8'h00;
      ale_lo    = 1'b0;
      ale_hi    = 1'b0;
      mem_oe_n  = 1'b1;
      mem_we_n  = 1'b1;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = S_ADL;
         end
         S_ADL: begin
            uio_out   = addr_q[7:0];
            uio_oe    = 8'hFF;
            ale_lo    = 1'b1;
            state_nxt = hi_skip ? S_DATA : S_ADH;
         end
         S_ADH: begin
            uio_out   = addr_q[15:8];
            uio_oe    = 8'hFF;
            ale_hi    = 1'b1;
            state_nxt = S_DATA;
         end
         S_DATA: begin
            if (rw_q) begin
               mem_oe_n = 1'b0;
            end else begin
               uio_out  = wdata_q;
               uio_oe   = 8'hFF;
               mem_we_n = 1'b0;
            end
            if (wait_cnt == 3'd0) state_nxt = S_DONE;
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Everything holds while clk_enable is low; read data is captured on the last DATA cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rw_q      <= 1'b0;
         addr_q    <= 16'h0000;
         wdata_q   <= 8'h00;
         hi_valid  <= 1'b0;
         last_hi   <= 8'h00;
         wait_cnt  <= 3'd0;
         rsp_rdata <= 8'h00;
      end else if (clk_enable) begin
         state <= state_nxt;
         if (state == S_IDLE && req_valid) begin
            rw_q    <= req_rw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state != S_DATA && state_nxt == S_DATA) begin
            wait_cnt <= WaitLoad;
         end else if (state == S_DATA && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (state == S_ADH) begin
            hi_valid <= 1'b1;
            last_hi  <= addr_q[15:8];
         end
         if (state == S_DATA && wait_cnt == 3'd0 && rw_q) begin
            rsp_rdata <= uio_in;
         end
      end
   end

endmodule

// File: doc/bus_interface_unit.md
BUS_INTERFACE_UNIT -- requirements
Module: bus_interface_unit

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: extra DATA-phase cycles before sample/release, legal range 0..7.
REQ-002 SHALL have clk, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have clk_enable, input, 1: advance enable; when low, all state, counters and outputs hold.
REQ-005 SHALL have req_valid, input, 1: core requests a bus transfer.
REQ-006 SHALL have req_rw, input, 1: 1 = read, 0 = write.
REQ-007 SHALL have req_addr, input, 16: transfer address.
REQ-008 SHALL have req_wdata, input, 8: write data.
REQ-009 SHALL have req_ready, output, 1: request accepted this cycle if high with req_valid and clk_enable.
REQ-010 SHALL have rsp_valid, output, 1: one-cycle pulse, transfer complete.
REQ-011 SHALL have rsp_rdata, output, 8: last read byte, held until the next read completes.
REQ-012 SHALL have uio_in, input, 8; uio_out, output, 8; uio_oe, output, 8: shared multiplexed address/data pins.
REQ-013 SHALL have ale_lo, ale_hi, output, 1 each: active-high latch strobes for external address-low and address-high latches.
REQ-014 SHALL have mem_oe_n, mem_we_n, output, 1 each: active-low memory read/write strobes.

Function
REQ-015 SHALL implement states IDLE, ADL, ADH, DATA, DONE; state advances only on edges where clk_enable=1.
REQ-016 SHALL drive req_ready=1 only in IDLE; acceptance captures req_rw, req_addr, req_wdata into internal registers; inputs are ignored at all other times.
REQ-017 IDLE: uio_oe=8'h00, all strobes inactive; on acceptance -> ADL.
REQ-018 ADL: uio_out=addr[7:0], uio_oe=8'hFF, ale_lo=1 -> ADH, or -> DATA when the high-byte skip condition holds.
REQ-019 High-byte skip: hi_valid=1 and addr[15:8] equals the stored last_hi; hi_valid is cleared by reset and set, with last_hi updated, on every ADH completion.
REQ-020 ADH: uio_out=addr[15:8], uio_oe=8'hFF, ale_hi=1 -> DATA.
REQ-021 DATA lasts WAIT_STATES+1 enabled cycles, counted by a 3-bit counter loaded with WAIT_STATES on DATA entry and decremented each enabled cycle.
REQ-022 DATA write: uio_out=wdata, uio_oe=8'hFF, mem_we_n=0 throughout.
REQ-023 DATA read: uio_oe=8'h00, mem_oe_n=0 throughout; uio_in is sampled into rsp_rdata on the final DATA cycle (counter=0) only.
REQ-024 DONE: rsp_valid=1 for exactly one enabled cycle, pins released (uio_oe=0), -> IDLE.
REQ-025 Latency from acceptance edge to rsp_valid: 3+WAIT_STATES cycles without skip, 2+WAIT_STATES with skip; minimum accepted-request spacing is one IDLE cycle after DONE.
REQ-026 Strobes are mutually exclusive; ale_lo, ale_hi, mem_oe_n and mem_we_n are never active together in any cycle.
REQ-027 Address 16'hFFFF and wdata 8'hFF SHALL pass unmodified; there is no address increment or wrap logic.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk: set state=IDLE, uio_out=0, uio_oe=0, ale_lo=ale_hi=0, mem_oe_n=mem_we_n=1, rsp_valid=0, rsp_rdata=0, hi_valid=0, last_hi=0, counter=0.
REQ-029 Reset mid-transfer SHALL abort it with no rsp_valid; the first post-reset transfer always executes ADH.

Verification
REQ-030 Read, WAIT_STATES=1, addr=16'h12A5, uio_in=8'h3C -> ADL(uio_out=A5), ADH(12), DATA x2 with oe=0, rsp_valid on cycle 5, rsp_rdata=3C.
REQ-031 Write addr=16'h12A6, wdata=8'h77 immediately after REQ-030 -> ADH skipped, mem_we_n=0 with uio_out=77 for 2 cycles, rsp_valid on cycle 4.
REQ-032 clk_enable toggled 0/1 every cycle during a read -> identical phase sequence stretched 2x, no extra pulses, same rsp_rdata.
REQ-033 rst_n asserted during DATA of a write -> uio_oe=0 and mem_we_n=1 before the next clk edge; no rsp_valid; next read of 16'h12A5 executes ADH.
REQ-034 WAIT_STATES=0 read of 16'hFFFF, uio_in=8'hFF -> single DATA cycle, rsp_rdata=FF, latency 3.
REQ-035 req_valid held high continuously -> req_ready high only in IDLE; every transfer separated by exactly one IDLE cycle.
